// File: rtl/mult_arb_7.sv
// mult_arb_7: arbitrates NUM_REQ requesters onto one shared 8x8 pipelined multiplier and routes
// each product back to its owner in issue order through an in-flight tag FIFO.
//
// Build option: define MULT_ARB_7_RR_EN for round-robin arbitration (search starts one past the
// last granted index). Without it the lowest requesting index always wins.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_a/b   per-requester operand pairs (requester i at bits [8i+7:8i])
//   req_ready           combinational one-hot grant (or zero)
//   halt                stop granting; in-flight operations still complete
//   mul_en/mul_a/mul_b  registered issue to the multiplier
//   mul_result/mul_rdy  multiplier product and its strobe
//   rsp_valid/data/id   registered one-cycle response to the owning requester
//   busy                FSM is not idle
//   err                 sticky: multiplier strobed with nothing in flight
module mult_arb_7 #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_a,
  input  logic [NUM_REQ*8-1:0]       req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       halt,
  output logic                       mul_en,
  output logic [7:0]                 mul_a,
  output logic [7:0]                 mul_b,
  input  logic [15:0]                mul_result,
  input  logic                       mul_rdy,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [15:0]                rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [IdW-1:0]     tag_q [DEPTH];
  logic               can_grant, gnt_any, push, pop;
  logic [IdW-1:0]     gnt_idx, pop_id;
  logic               mul_en_q;
  logic [7:0]         mul_a_q, mul_b_q;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q;
  logic [IdW-1:0]     rsp_id_q;
  logic               err_q;

  // A full FIFO may still accept one grant when a pop frees a slot in the same cycle.
  assign can_grant = !rst && !halt && ((count_q != CntW'(DEPTH)) || mul_rdy);

`ifdef MULT_ARB_7_RR_EN
  logic [IdW-1:0] rr_ptr_q;
  logic [IdW:0]   rr_cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_cand = '0;
    if (can_grant) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        rr_cand = {1'b0, rr_ptr_q} + (IdW + 1)'(k);
        if (rr_cand >= (IdW + 1)'(NUM_REQ)) rr_cand = rr_cand - (IdW + 1)'(NUM_REQ);
        if (!gnt_any && req_valid[rr_cand[IdW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = rr_cand[IdW-1:0];
        end
      end
    end
  end

  // Pointer holds the index one past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (gnt_any) begin
      rr_ptr_q <= (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdW'(1);
    end
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (can_grant) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && req_valid[k]) begin
          gnt_any = 1'b1;
          gnt_idx = IdW'(k);
        end
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Issue stage: operands hold their last value when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_en_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      mul_en_q <= gnt_any;
      if (gnt_any) begin
        mul_a_q <= req_a[8*gnt_idx +: 8];
        mul_b_q <= req_b[8*gnt_idx +: 8];
      end
    end
  end

  // In-order tag FIFO. A strobe with nothing in flight is a protocol error, not a pop.
  assign push   = gnt_any;
  assign pop    = mul_rdy && (count_q != '0);
  assign pop_id = tag_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (mul_rdy && (count_q == '0)) err_q <= 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    if (pop) rsp_valid_d[pop_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= pop ? mul_result : '0;
      rsp_id_q    <= pop ? pop_id : '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state, judged on the post-pop count
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) state_d = StActive;
      end
      StActive: begin
        if (halt && (count_d != '0))              state_d = StDrain;
        else if ((count_d == '0) && !gnt_any)     state_d = StIdle;
      end
      StDrain: begin
        if (count_d == '0) state_d = StIdle;
        else if (!halt)    state_d = StActive;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  assign mul_en    = mul_en_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mult_arb_7.sv
// tb_mult_arb_7: scoreboard bench for mult_arb_7 (NUM_REQ=4, DEPTH=8) with a behavioural
// 8-cycle multiplier. Grants push expected products; responses pop and compare.
module tb_mult_arb_7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        halt = 1'b0;
  logic        mul_en;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_result;
  logic        mul_rdy;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy, err;

  mult_arb_7 #(.NUM_REQ(4), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .halt       (halt),
    .mul_en     (mul_en),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_rdy    (mul_rdy),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } exp_t;

  typedef struct {
    int          due;
    logic [15:0] prod;
  } mq_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   rsp_cnt = 0;
  bit   lat_chk = 1'b1;
  bit   rdy_hold = 1'b0;
  bit   inj_rdy = 1'b0;

  // Behavioural multiplier: result strobes 8 cycles after en, reset along with the DUT.
  initial begin
    mq_t mq[$];
    mul_rdy    = 1'b0;
    mul_result = '0;
    forever begin
      @(posedge clk);
      #2;
      mul_rdy    = 1'b0;
      mul_result = '0;
      if (inj_rdy) begin
        mul_rdy    = 1'b1;
        mul_result = 16'hbeef;
      end else if (!rdy_hold && mq.size() > 0 && mq[0].due <= cyc) begin
        mul_rdy    = 1'b1;
        mul_result = mq[0].prod;
        void'(mq.pop_front());
      end
      @(negedge clk);
      if (rst) mq.delete();
      else if (mul_en) mq.push_back('{due: cyc + 8, prod: {8'd0, mul_a} * {8'd0, mul_b}});
    end
  end

  // Monitor: records grants into the scoreboard and checks every response.
  initial begin
    exp_t        e;
    int          idx;
    logic [15:0] pa, pb;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.prod));
            if (lat_chk) check("rsp_latency", 32'(cyc), 32'(e.due));
            rsp_cnt++;
          end
        end else begin
          check("rsp_idle_zero", {rsp_id, rsp_data}, 32'd0);
        end
        if (req_ready != '0) begin
          check("gnt_onehot", 32'($countones(req_ready)), 32'd1);
          check("gnt_to_valid", 32'(req_ready & ~req_valid), 32'd0);
          idx = 0;
          for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
          pa = {8'd0, req_a[8*idx +: 8]};
          pb = {8'd0, req_b[8*idx +: 8]};
          sb.push_back('{id: idx, prod: pa * pb, due: cyc + 10});
          gnt_log.push_back(idx);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; req_valid = '0; halt = 1'b0; inj_rdy = 1'b0; rdy_hold = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(posedge clk);
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_mul_en"}, 32'(mul_en), 32'd0);
    check({tag, "_mul_ab"}, {16'd0, mul_a, mul_b}, 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, {14'd0, rsp_id, rsp_data}, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n0, c0;
    logic [3:0] exp_gnt;

    // Reset state, with requests pending to prove req_ready stays low during reset.
    rst = 1'b1;
    req_valid = 4'hf;
    repeat (2) @(posedge clk);
    sample();
    check_all_zero("reset");
    step();
    rst = 1'b0;
    req_valid = '0;

    // Single request from requester 2: 13*11 = 143 after 10 cycles.
    step();
    req_valid = 4'b0100; req_a = 32'h000d_0000; req_b = 32'h000b_0000;
    sample();
    check("single_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    sample();
    check("single_mul_en", 32'(mul_en), 32'd1);
    check("single_ops", {16'd0, mul_a, mul_b}, 32'h0000_0d0b);
    check("single_busy", 32'(busy), 32'd1);
    step();
    sample();
    check("single_en_drop", 32'(mul_en), 32'd0);
    check("single_ops_hold", {16'd0, mul_a, mul_b}, 32'h0000_0d0b);
    wait_drain(20);
    step();
    sample();
    check("single_idle", 32'(busy), 32'd0);

    // Arbitration with all four requesting.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      req_valid = 4'hf; req_a = $urandom; req_b = $urandom;
`ifdef MULT_ARB_7_RR_EN
      exp_gnt = 4'b0001 << (k % 4);
`else
      exp_gnt = 4'b0001;
`endif
      sample();
      check("arb_grant", 32'(req_ready), 32'(exp_gnt));
    end
    step();
    req_valid = '0;
    wait_drain(30);

    // FIFO full with results withheld, then one grant alongside the first pop.
    do_reset();
    lat_chk  = 1'b0;
    rdy_hold = 1'b1;
    n0 = gnt_log.size();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      req_valid = 4'hf; req_a = $urandom; req_b = $urandom;
    end
    sample();
    check("full_ready_zero", 32'(req_ready), 32'd0);
    check("full_grant_count", 32'(gnt_log.size() - n0), 32'd8);
    step();
    rdy_hold = 1'b0;
    sample();
    check("full_regrant", 32'($countones(req_ready)), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      req_a = $urandom; req_b = $urandom;
    end
    step();
    req_valid = '0;
    wait_drain(80);
    lat_chk = 1'b1;

    // Halt with three in flight: no grants, three responses, then idle.
    do_reset();
    c0 = rsp_cnt;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      req_valid = 4'b0001; req_a = $urandom; req_b = $urandom;
    end
    step();
    halt = 1'b1;
    req_valid = 4'hf;
    sample();
    check("halt_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) begin
        step();
        sample();
      end
      check("halt_ready_zero", 32'(req_ready), 32'd0);
    end
    check("halt_rsp_count", 32'(rsp_cnt - c0), 32'd3);
    check("halt_idle", 32'(busy), 32'd0);
    step();
    halt = 1'b0;
    req_valid = '0;

    // Multiplier strobe with nothing in flight: sticky error, cleared by reset.
    do_reset();
    step();
    inj_rdy = 1'b1;
    step();
    inj_rdy = 1'b0;
    sample();
    check("err_set", 32'(err), 32'd1);
    check("err_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (5) step();
    sample();
    check("err_sticky", 32'(err), 32'd1);
    do_reset();
    sample();
    check("err_cleared", 32'(err), 32'd0);

    // Reset with five in flight: everything cleared, no stale responses.
    c0 = rsp_cnt;
    for (int k = 0; k < 5; k++) begin
      step();
      req_valid = 4'b0001; req_a = $urandom; req_b = $urandom;
    end
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check_all_zero("midrst");
    repeat (20) step();
    check("midrst_no_rsp", 32'(rsp_cnt - c0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
